// File: rtl/reg_8_pkg.sv
// Shared constants and types for the reg_8 enable-gated data register.
package reg_8_pkg;

    localparam int REG_8_DEFAULT_WIDTH = 8;

    typedef logic [REG_8_DEFAULT_WIDTH-1:0] reg_8_data_t;

endpackage : reg_8_pkg

// File: rtl/reg_8_if.sv
// Load/clear/data bus of reg_8. The q_par signal exists only when REG_8_PARITY_EN is defined.
import reg_8_pkg::*;

interface reg_8_if #(
    parameter int WIDTH = REG_8_DEFAULT_WIDTH
);
    logic             clr;
    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             q_valid;
`ifdef REG_8_PARITY_EN
    logic             q_par;

    modport master (output clr, en, d, input q, q_valid, q_par);
    modport slave  (input clr, en, d, output q, q_valid, q_par);
`else
    modport master (output clr, en, d, input q, q_valid);
    modport slave  (input clr, en, d, output q, q_valid);
`endif
endinterface : reg_8_if

// File: rtl/reg_8_par_gen.sv
// Combinational even-parity generator: o_par is 1 when i_data has an odd number of ones.
module reg_8_par_gen #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_par
);
    assign o_par = ^i_data;
endmodule : reg_8_par_gen

// File: rtl/reg_8.sv
// Enable-gated register with sync reset, sync clear and a loaded flag.
// Define REG_8_PARITY_EN to add a registered even-parity output (q_par).
import reg_8_pkg::*;

module reg_8 #(
    parameter int               WIDTH     = REG_8_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input logic    clk,
    input logic    reset,
    reg_8_if.slave bus
);
    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic [WIDTH-1:0] w_next_q;
    logic             w_next_valid;

    // Priority below reset: clr, then en, else hold.
    always_comb begin
        w_next_q     = r_q;
        w_next_valid = r_valid;
        if (bus.clr) begin
            w_next_q     = RESET_VAL;
            w_next_valid = 1'b0;
        end else if (bus.en) begin
            w_next_q     = bus.d;
            w_next_valid = 1'b1;
        end
    end

`ifdef REG_8_PARITY_EN
    logic r_par;
    logic w_next_par;

    reg_8_par_gen #(.WIDTH(WIDTH)) u_par_gen (
        .i_data (w_next_q),
        .o_par  (w_next_par)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= RESET_VAL;
            r_valid <= 1'b0;
            r_par   <= ^RESET_VAL;
        end else begin
            r_q     <= w_next_q;
            r_valid <= w_next_valid;
            r_par   <= w_next_par;
        end
    end

    assign bus.q_par = r_par;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= RESET_VAL;
            r_valid <= 1'b0;
        end else begin
            r_q     <= w_next_q;
            r_valid <= w_next_valid;
        end
    end
`endif

    assign bus.q       = r_q;
    assign bus.q_valid = r_valid;

endmodule : reg_8

// File: tb/tb_reg_8.sv
// Directed self-checking bench for reg_8: default 8-bit instance and a 16-bit instance with RESET_VAL=0xA5A5.
module tb_reg_8;
    import reg_8_pkg::*;

    logic clk;
    logic rst8;
    logic rst16;
    int   checks;
    int   errors;

    reg_8_if #(.WIDTH(8))  bus8  ();
    reg_8_if #(.WIDTH(16)) bus16 ();

    reg_8 u_dut8 (
        .clk   (clk),
        .reset (rst8),
        .bus   (bus8)
    );

    reg_8 #(.WIDTH(16), .RESET_VAL(16'hA5A5)) u_dut16 (
        .clk   (clk),
        .reset (rst16),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst8 = 1'b0;
        rst16 = 1'b1;
        bus8.clr = 1'b0;  bus8.en = 1'b0;  bus8.d = 8'h48;
        bus16.clr = 1'b0; bus16.en = 1'b0; bus16.d = 16'h0000;

        // Power-up cycle, then reset with en high: d must not be loaded.
        step();
        rst8 = 1'b1; bus8.en = 1'b1; bus8.d = 8'h09;
        step();
        check("rst_q", {24'h0, bus8.q}, 32'h00);
        check("rst_valid", {31'h0, bus8.q_valid}, 32'h0);
        check("w16_rst_q", {16'h0, bus16.q}, 32'hA5A5);
        check("w16_rst_valid", {31'h0, bus16.q_valid}, 32'h0);
`ifdef REG_8_PARITY_EN
        check("rst_par", {31'h0, bus8.q_par}, 32'h0);
        check("w16_rst_par", {31'h0, bus16.q_par}, 32'h0);
`endif

        // Load.
        rst8 = 1'b0; bus8.en = 1'b1; bus8.d = 8'h5C;
        rst16 = 1'b0; bus16.en = 1'b1; bus16.d = 16'h1234;
        step();
        check("load_q", {24'h0, bus8.q}, 32'h5C);
        check("load_valid", {31'h0, bus8.q_valid}, 32'h1);
        check("w16_load_q", {16'h0, bus16.q}, 32'h1234);
        check("w16_load_valid", {31'h0, bus16.q_valid}, 32'h1);
`ifdef REG_8_PARITY_EN
        check("load_par_5c", {31'h0, bus8.q_par}, 32'h0);
        check("w16_par_1234", {31'h0, bus16.q_par}, 32'h1);
`endif
        bus16.en = 1'b0; bus16.d = 16'hFFFF;
        bus8.d = 8'h11;
        step();
        check("load2_q", {24'h0, bus8.q}, 32'h11);
        check("w16_hold_q", {16'h0, bus16.q}, 32'h1234);

        // Hold with changing d.
        bus8.en = 1'b0; bus8.d = 8'h6C;
        step();
        check("hold1_q", {24'h0, bus8.q}, 32'h11);
        check("hold1_valid", {31'h0, bus8.q_valid}, 32'h1);
        bus8.d = 8'h4C;
        step();
        check("hold2_q", {24'h0, bus8.q}, 32'h11);
        check("hold2_valid", {31'h0, bus8.q_valid}, 32'h1);

        // clr beats en.
        bus8.clr = 1'b1; bus8.en = 1'b1; bus8.d = 8'hFF;
        step();
        check("clr_q", {24'h0, bus8.q}, 32'h00);
        check("clr_valid", {31'h0, bus8.q_valid}, 32'h0);

        // Reload, then reset beats en.
        bus8.clr = 1'b0; bus8.d = 8'h33;
        step();
        check("reload_q", {24'h0, bus8.q}, 32'h33);
        rst8 = 1'b1; bus8.d = 8'h77;
        step();
        check("rst_en_q", {24'h0, bus8.q}, 32'h00);
        check("rst_en_valid", {31'h0, bus8.q_valid}, 32'h0);

        // Reset released with en high: loads at the first non-reset edge.
        rst8 = 1'b0; bus8.d = 8'h54;
        step();
        check("rel_q", {24'h0, bus8.q}, 32'h54);
        check("rel_valid", {31'h0, bus8.q_valid}, 32'h1);
`ifdef REG_8_PARITY_EN
        check("load_par_54", {31'h0, bus8.q_par}, 32'h1);
`endif

        // Loading the value already held still sets q_valid.
        bus8.clr = 1'b1; bus8.en = 1'b0;
        step();
        check("clr2_valid", {31'h0, bus8.q_valid}, 32'h0);
        bus8.clr = 1'b0; bus8.en = 1'b1; bus8.d = 8'h00;
        step();
        check("same_q", {24'h0, bus8.q}, 32'h00);
        check("same_valid", {31'h0, bus8.q_valid}, 32'h1);

        // clr with en low on the wide instance restores RESET_VAL.
        bus16.clr = 1'b1;
        step();
        check("w16_clr_q", {16'h0, bus16.q}, 32'hA5A5);
        check("w16_clr_valid", {31'h0, bus16.q_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_reg_8

// File: doc/reg_8.md
# reg_8

Enable-gated data register, 8 bits by default, with synchronous active-high reset and synchronous clear. It is the basic storage element for datapath staging and configuration holding: a value presented on `d` is captured on a rising clock edge only when `en` is high, and otherwise held indefinitely. A `q_valid` flag reports whether the register has been loaded since the last reset or clear.

## Interface
Parameters:
- `WIDTH`, default 8: data width in bits; must be at least 1.
- `RESET_VAL`, default `{WIDTH{1'b0}}`: value loaded into `q` by `reset` and by `clr`.

Ports:
- `clk`, input, 1 bit: rising-edge clock; the block's only clock.
- `reset`, input, 1 bit: synchronous, active-high reset; sampled on the rising edge of `clk`.
- `clr`, input, 1 bit: synchronous clear, active-high.
- `en`, input, 1 bit: load enable, active-high.
- `d`, input, `WIDTH` bits: data to capture.
- `q`, output, `WIDTH` bits: registered data.
- `q_valid`, output, 1 bit: high once `q` holds a value loaded through `en`.
- `q_par`, output, 1 bit: even parity of `q`. Present only with `REG_8_PARITY_EN`.

## Operation
- Actions are evaluated at each rising edge of `clk`, in this priority order:
  - `reset`=1: `q` <= `RESET_VAL`, `q_valid` <= 0. All other inputs are ignored.
  - else `clr`=1: `q` <= `RESET_VAL`, `q_valid` <= 0. `en` is ignored.
  - else `en`=1: `q` <= `d`, `q_valid` <= 1.
  - else: `q` and `q_valid` hold their values.
- Reset values: `q` = `RESET_VAL`, `q_valid` = 0, `q_par` = XOR-reduction of `RESET_VAL`.
- The register does no arithmetic. `d` is captured bit-exact, with no width conversion.
- Loading the value `q` already holds still sets `q_valid`.
- Before the first `reset` edge, `q` and `q_valid` are undefined. No initial value is implied.

## Timing
- Load latency is 1 cycle: `d` sampled at edge N appears on `q` immediately after edge N.
- Changes on `d` or `en` between edges have no effect on `q`. No output is combinational from `d` or `en`.
- A `reset` pulse shorter than one clock period that does not span a rising edge has no effect.
- If `reset` is asserted in the same cycle as `en`=1, reset wins. The `d` value of that cycle is lost.
- When `reset` deasserts with `en`=1, `d` is loaded at the first edge where `reset`=0.
- `q_par` is registered alongside `q` and updates on the same edge as `q`, with zero extra latency.

## Configuration
- `REG_8_PARITY_EN` defined: the `q_par` port exists. It is a flop updated with `^next_q` whenever `q` updates, so `q_par` == `^q` at all times after reset.
- `REG_8_PARITY_EN` undefined: the `q_par` port and its flop are absent. All other behaviour is identical.

## Structure
- The shared package `reg_8_pkg` holds `REG_8_DEFAULT_WIDTH` (8) and a `reg_8_data_t` typedef (`logic [REG_8_DEFAULT_WIDTH-1:0]`).
- One sub-module is natural: `reg_8_par_gen`, a combinational even-parity generator on `WIDTH` bits. It is instantiated only under `REG_8_PARITY_EN`.
- All state sits in a single clocked process, with the priority `reset` > `clr` > `en`.

## Test plan
- Power-up hold: `reset`=0, `en`=0, `d`=0x48 for 1 cycle, then `reset`=1, `d`=0x09 for 1 cycle -> after the reset edge, `q`=0x00 and `q_valid`=0. `d`=0x09 is not loaded.
- Load: `reset`=0, `en`=1, `d`=0x5C -> `q`=0x5C and `q_valid`=1 after the next edge. Then `d`=0x11 -> `q`=0x11 the following edge.
- Hold: `en`=0, `d`=0x6C then 0x4C over 2 cycles -> `q` stays 0x11 and `q_valid` stays 1.
- Priority: with `q`=0x11, set `clr`=1, `en`=1, `d`=0xFF -> `q`=0x00, `q_valid`=0. Then `reset`=1 and `en`=1 -> `q`=0x00.
- Parameters: `WIDTH`=16, `RESET_VAL`=0xA5A5, `reset` then `en` with `d`=0x1234 -> `q`=0xA5A5, then `q`=0x1234.
- Parity (`REG_8_PARITY_EN`): load 0x5C -> `q_par`=0. Load 0x54 -> `q_par`=1. Both update in the same cycle as `q`.
